// File: rtl/instrom_pkg.sv
// rtl/instrom_pkg.sv - shared states and defaults for the instruction-memory responder
package instrom_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } load_state_e;

  localparam logic [31:0] DEFAULT_NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/instrom_responder_if.sv
// rtl/instrom_responder_if.sv - fetch port and program-load port bundle
interface instrom_responder_if #(
  parameter int DEPTH_WORDS = 4096
);
  localparam int WW = $clog2(DEPTH_WORDS) + 1;

  logic [31:0]   openmips_instrom_addr;
  logic          openmips_instrom_ren;
  logic [31:0]   instrom_openmips_data;
  logic          fetch_err;
  logic          load_en;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_ready;
  logic          load_busy;
  logic          load_overflow;
  logic [WW-1:0] load_words;

  modport master (
    output openmips_instrom_addr, openmips_instrom_ren, load_en, load_valid, load_byte,
    input  instrom_openmips_data, fetch_err, load_ready, load_busy, load_overflow, load_words
  );

  modport slave (
    input  openmips_instrom_addr, openmips_instrom_ren, load_en, load_valid, load_byte,
    output instrom_openmips_data, fetch_err, load_ready, load_busy, load_overflow, load_words
  );
endinterface

// File: rtl/instrom_sram.sv
// rtl/instrom_sram.sv - 1R1W word array with registered read port, kept apart for block-RAM inference
module instrom_sram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instrom_responder.sv
// rtl/instrom_responder.sv - fetch responder with byte-stream program loader
module instrom_responder
  import instrom_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST
) (
  input logic               clk,
  input logic               rst,
  instrom_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  load_state_e state, state_next;
  logic [AW:0]   wr_ptr, wr_ptr_next;
  logic [1:0]    byte_cnt, byte_cnt_next;
  logic [23:0]   lanes, lanes_next;
  logic          mem_we, mem_re;
  logic [31:0]   mem_wdata, mem_rdata, offset;
  logic          full, accept, fetch_hit;
  logic          load_ready_q, load_busy_q, overflow_q, sel_mem_q, fetch_err_q;

  assign full   = wr_ptr[AW];
  assign accept = (state == ST_LOAD) && bus.load_valid && load_ready_q;

  // Base is word aligned, so offset[1:0] is the address alignment.
  assign offset    = bus.openmips_instrom_addr - BASE_ADDR;
  assign fetch_hit = (bus.openmips_instrom_addr >= BASE_ADDR) && (offset[1:0] == 2'b00)
                     && (offset[31:AW+2] == '0);
  assign mem_re    = (state == ST_RUN) && bus.openmips_instrom_ren && fetch_hit;

  always_comb begin
    state_next    = state;
    wr_ptr_next   = wr_ptr;
    byte_cnt_next = byte_cnt;
    lanes_next    = lanes;
    mem_we        = 1'b0;
    mem_wdata     = {8'h00, lanes};
    case (state)
      ST_RUN: begin
        if (bus.load_en) begin
          state_next    = ST_LOAD;
          wr_ptr_next   = '0;
          byte_cnt_next = 2'd0;
          lanes_next    = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (byte_cnt == 2'd3) begin
            mem_we        = 1'b1;
            mem_wdata     = {bus.load_byte, lanes};
            wr_ptr_next   = wr_ptr + 1'b1;
            byte_cnt_next = 2'd0;
            lanes_next    = '0;
          end else begin
            case (byte_cnt)
              2'd0:    lanes_next[7:0]   = bus.load_byte;
              2'd1:    lanes_next[15:8]  = bus.load_byte;
              default: lanes_next[23:16] = bus.load_byte;
            endcase
            byte_cnt_next = byte_cnt + 2'd1;
          end
        end
        if (!bus.load_en) state_next = (byte_cnt_next == 2'd0) ? ST_RUN : ST_FLUSH;
      end
      ST_FLUSH: begin
        // A pending partial word implies room was left, so full never holds here.
        if (!full) begin
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr + 1'b1;
        end
        byte_cnt_next = 2'd0;
        lanes_next    = '0;
        state_next    = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_RUN;
      wr_ptr       <= '0;
      byte_cnt     <= 2'd0;
      lanes        <= '0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sel_mem_q    <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      byte_cnt     <= byte_cnt_next;
      lanes        <= lanes_next;
      load_ready_q <= (state_next == ST_LOAD) && !wr_ptr_next[AW];
      load_busy_q  <= (state_next != ST_RUN);
      if ((state == ST_LOAD) && bus.load_valid && full) overflow_q <= 1'b1;
      if (bus.openmips_instrom_ren) begin
        sel_mem_q   <= mem_re;
        fetch_err_q <= (state == ST_RUN) && !fetch_hit;
      end
    end
  end

  instrom_sram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (offset[AW+1:2]),
    .rdata (mem_rdata)
  );

  assign bus.instrom_openmips_data = sel_mem_q ? mem_rdata : NOP_INST;
  assign bus.fetch_err             = fetch_err_q;
  assign bus.load_ready            = load_ready_q;
  assign bus.load_busy             = load_busy_q;
  assign bus.load_overflow         = overflow_q;
  assign bus.load_words            = wr_ptr;
endmodule

// File: tb/tb_instrom_responder.sv
// tb/tb_instrom_responder.sv - randomized self-checking bench for instrom_responder
module tb_instrom_responder;
  localparam int          DEPTH  = 4096;
  localparam int          SDEPTH = 4;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instrom_responder_if #(.DEPTH_WORDS(DEPTH))  bus();
  instrom_responder_if #(.DEPTH_WORDS(SDEPTH)) sbus();

  instrom_responder #(.DEPTH_WORDS(DEPTH))  dut   (.clk(clk), .rst(rst), .bus(bus));
  instrom_responder #(.DEPTH_WORDS(SDEPTH)) dut_s (.clk(clk), .rst(rst), .bus(sbus));

  int total = 0;
  int bad   = 0;
  int max_written = 0;
  logic [31:0] ref_mem [int];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_load(input logic [7:0] b[$]);
    int n;
    int nw;
    logic [31:0] v;
    n  = b.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      v = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v[8*k +: 8] = b[4*w + k];
      ref_mem[w] = v;
    end
    if (nw > max_written) max_written = nw;
    return nw;
  endfunction

  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE || a[1:0] != 2'b00 || (off >> 2) >= 32'(DEPTH)) return {1'b1, NOP};
    return {1'b0, ref_mem[int'(off >> 2)]};
  endfunction

  task automatic fetch(input logic [31:0] a, output logic [32:0] got);
    bus.openmips_instrom_addr = a;
    bus.openmips_instrom_ren  = 1'b1;
    step();
    got = {bus.fetch_err, bus.instrom_openmips_data};
    bus.openmips_instrom_ren  = 1'b0;
  endtask

  task automatic load_seq(input logic [7:0] b[$], input bit drop_with_last, input bit gaps,
                          output logic busy_after);
    bus.load_en = 1'b1;
    step();
    foreach (b[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.load_valid = 1'b0;
        step();
      end
      bus.load_valid = 1'b1;
      bus.load_byte  = b[i];
      if (drop_with_last && i == b.size() - 1) bus.load_en = 1'b0;
      step();
    end
    bus.load_valid = 1'b0;
    if (!drop_with_last) begin
      bus.load_en = 1'b0;
      step();
    end
    busy_after = bus.load_busy;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if ({bus.fetch_err, bus.instrom_openmips_data} !== {1'b0, NOP}) begin
      bad++;
      $display("FAIL reset_data: got err=%b data=%h want err=0 data=%h",
               bus.fetch_err, bus.instrom_openmips_data, NOP);
    end
    total++;
    if ({bus.load_ready, bus.load_busy, bus.load_overflow} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got ready/busy/ovf=%b%b%b want 000",
               bus.load_ready, bus.load_busy, bus.load_overflow);
    end
    total++;
    if (bus.load_words !== '0) begin
      bad++;
      $display("FAIL reset_words: got %0d want 0", bus.load_words);
    end
  endtask

  task automatic test_program_load();
    logic [7:0]  b[$];
    logic        busy;
    logic [32:0] got;
    int          nw;
    b  = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
    load_seq(b, 1'b0, 1'b0, busy);
    nw = model_load(b);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL prog_no_flush: got busy=%b want 0", busy);
    end
    total++;
    if (bus.load_words !== 13'(nw)) begin
      bad++;
      $display("FAIL prog_words: got %0d want %0d", bus.load_words, nw);
    end
    fetch(32'h8000_0000, got);
    total++;
    if (got !== {1'b0, 32'h0010_0513}) begin
      bad++;
      $display("FAIL prog_word0: got %h want %h", got, {1'b0, 32'h0010_0513});
    end
    fetch(32'h8000_0004, got);
    total++;
    if (got !== {1'b0, 32'h00A5_05B3}) begin
      bad++;
      $display("FAIL prog_word1: got %h want %h", got, {1'b0, 32'h00A5_05B3});
    end
  endtask

  task automatic test_flush();
    logic [7:0]  b[$];
    logic        busy;
    logic [32:0] got;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom_range(1, 255)));
    load_seq(b, 1'b1, 1'b0, busy);
    void'(model_load(b));
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy: got busy=%b want 1", busy);
    end
    total++;
    if (bus.load_words !== 13'd2 || bus.load_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_words: got words=%0d busy=%b want words=2 busy=0",
               bus.load_words, bus.load_busy);
    end
    fetch(32'h8000_0004, got);
    total++;
    if (got !== model_fetch(32'h8000_0004) || got[31:16] !== 16'h0) begin
      bad++;
      $display("FAIL flush_word1: got %h want %h", got, model_fetch(32'h8000_0004));
    end
  endtask

  task automatic test_fetch_faults();
    logic [31:0] addrs[$];
    logic [32:0] got;
    addrs = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_0002, 32'hFFFF_FFFC};
    foreach (addrs[i]) begin
      fetch(addrs[i], got);
      total++;
      if (got !== {1'b1, NOP}) begin
        bad++;
        $display("FAIL fault_%h: got %h want %h", addrs[i], got, {1'b1, NOP});
      end
    end
    bus.openmips_instrom_addr = 32'h8000_0000;
    step();
    total++;
    if ({bus.fetch_err, bus.instrom_openmips_data} !== {1'b1, NOP}) begin
      bad++;
      $display("FAIL fault_hold: got err=%b data=%h want err=1 data=%h",
               bus.fetch_err, bus.instrom_openmips_data, NOP);
    end
  endtask

  task automatic test_fetch_during_load();
    logic [32:0] got;
    bus.load_en = 1'b1;
    step();
    fetch(32'h8000_0000, got);
    total++;
    if (got !== {1'b0, NOP}) begin
      bad++;
      $display("FAIL load_fetch_hit: got %h want %h", got, {1'b0, NOP});
    end
    fetch(32'h7000_0001, got);
    total++;
    if (got !== {1'b0, NOP}) begin
      bad++;
      $display("FAIL load_fetch_bad: got %h want %h", got, {1'b0, NOP});
    end
    bus.load_en = 1'b0;
    step();
    total++;
    if (bus.load_busy !== 1'b0 || bus.load_words !== '0) begin
      bad++;
      $display("FAIL empty_load: got busy=%b words=%0d want busy=0 words=0",
               bus.load_busy, bus.load_words);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b[$];
    logic        busy;
    logic [32:0] got, exp;
    logic [31:0] a;
    int          nw;
    for (int it = 0; it < 4; it++) begin
      b.delete();
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) b.push_back(8'($urandom));
      load_seq(b, 1'($urandom_range(0, 1)), 1'b1, busy);
      nw = model_load(b);
      total++;
      if (bus.load_words !== 13'(nw)) begin
        bad++;
        $display("FAIL rand_words_%0d: got %0d want %0d", it, bus.load_words, nw);
      end
      for (int f = 0; f < 25; f++) begin
        case ($urandom_range(0, 3))
          0, 1:    a = BASE + 32'($urandom_range(0, max_written - 1)) * 4;
          2:       a = BASE + 32'($urandom_range(0, max_written - 1)) * 4 + 32'($urandom_range(1, 3));
          default: a = $urandom_range(0, 1) ? BASE - 32'($urandom_range(1, 1000))
                                            : BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
        endcase
        exp = model_fetch(a);
        fetch(a, got);
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL rand_fetch_%h: got %h want %h", a, got, exp);
        end
        if ($urandom_range(0, 3) == 0) begin
          bus.openmips_instrom_addr = $urandom;
          step();
          total++;
          if ({bus.fetch_err, bus.instrom_openmips_data} !== exp) begin
            bad++;
            $display("FAIL rand_hold: got %h want %h",
                     {bus.fetch_err, bus.instrom_openmips_data}, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0]  b[$];
    logic [32:0] got, exp;
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    bus.load_en = 1'b1;
    step();
    foreach (b[i]) begin
      bus.load_valid = 1'b1;
      bus.load_byte  = b[i];
      step();
    end
    bus.load_byte = 8'($urandom);
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_en    = 1'b0;
    b.pop_back();
    void'(model_load(b));
    total++;
    if ({bus.load_busy, bus.load_ready} !== 2'b00 || bus.load_words !== '0) begin
      bad++;
      $display("FAIL rst_mid_load: got busy=%b ready=%b words=%0d want 0 0 0",
               bus.load_busy, bus.load_ready, bus.load_words);
    end
    for (int w = 0; w < 2; w++) begin
      exp = model_fetch(BASE + 32'(w * 4));
      fetch(BASE + 32'(w * 4), got);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rst_keep_word%0d: got %h want %h", w, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp3;
    exp3 = 32'h0;
    for (int k = 0; k < 4; k++) exp3[8*k +: 8] = 8'(13 + k);
    sbus.load_en = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      sbus.load_valid = 1'b1;
      sbus.load_byte  = 8'(i + 1);
      step();
      if (i == 14) begin
        total++;
        if (sbus.load_ready !== 1'b1) begin
          bad++;
          $display("FAIL ovf_ready_b15: got %b want 1", sbus.load_ready);
        end
      end
      if (i == 15) begin
        total++;
        if ({sbus.load_ready, sbus.load_overflow} !== 2'b00 || sbus.load_words !== 3'd4) begin
          bad++;
          $display("FAIL ovf_full: got ready=%b ovf=%b words=%0d want 0 0 4",
                   sbus.load_ready, sbus.load_overflow, sbus.load_words);
        end
      end
    end
    total++;
    if (sbus.load_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b want 1", sbus.load_overflow);
    end
    sbus.load_valid = 1'b0;
    sbus.load_en    = 1'b0;
    step();
    sbus.openmips_instrom_addr = 32'h8000_000C;
    sbus.openmips_instrom_ren  = 1'b1;
    step();
    total++;
    if ({sbus.fetch_err, sbus.instrom_openmips_data} !== {1'b0, exp3}) begin
      bad++;
      $display("FAIL ovf_word3: got %h want %h",
               {sbus.fetch_err, sbus.instrom_openmips_data}, {1'b0, exp3});
    end
    sbus.openmips_instrom_addr = 32'h8000_0010;
    step();
    sbus.openmips_instrom_ren = 1'b0;
    total++;
    if ({sbus.fetch_err, sbus.instrom_openmips_data, sbus.load_overflow} !== {1'b1, NOP, 1'b1}) begin
      bad++;
      $display("FAIL ovf_boundary: got %h want %h",
               {sbus.fetch_err, sbus.instrom_openmips_data, sbus.load_overflow}, {1'b1, NOP, 1'b1});
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if (sbus.load_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got %b want 0", sbus.load_overflow);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.openmips_instrom_addr  = '0;
    bus.openmips_instrom_ren   = 1'b0;
    bus.load_en                = 1'b0;
    bus.load_valid             = 1'b0;
    bus.load_byte              = '0;
    sbus.openmips_instrom_addr = '0;
    sbus.openmips_instrom_ren  = 1'b0;
    sbus.load_en               = 1'b0;
    sbus.load_valid            = 1'b0;
    sbus.load_byte             = '0;
    test_reset();
    test_program_load();
    test_flush();
    test_fetch_faults();
    test_fetch_during_load();
    test_random();
    test_reset_mid_load();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
